// File: rtl/alu_pkg.sv
// Shared alu opcodes, sequencer command encodings and sequencer state enum.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_ORR   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_IDLE  = 4'b1111;

   localparam logic CMD_PASS = 1'b0;
   localparam logic CMD_MUL  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EXEC     = 2'd1,
      S_MUL_STEP = 2'd2,
      S_DONE     = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle command sequencer in front of the shared alu: single PASS ops and
// shift-and-add unsigned multiply using the alu adder, one step per cycle.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned OPW   = 4,
   parameter int unsigned CNTW  = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_cmd,
   input  logic [OPW-1:0]   req_aluop,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_z
);

   seq_state_t       state, state_d;
   logic [WIDTH-1:0] acc, acc_d, acc_step;
   logic [WIDTH-1:0] mcand, mcand_d;
   logic [WIDTH-1:0] mplier, mplier_d;
   logic [CNTW-1:0]  cnt, cnt_d;
   logic [WIDTH-1:0] opa, opa_d, opb, opb_d;
   logic [OPW-1:0]   aluop, aluop_d;
   logic [WIDTH-1:0] result_d;
   logic             zero_d;
   logic [WIDTH-1:0] alu_a_d, alu_b_d;
   logic [OPW-1:0]   alu_op_d;

   // Next-state, datapath and alu drive; the alu drive is registered from next state.
   always_comb begin
      state_d  = state;
      acc_d    = acc;
      mcand_d  = mcand;
      mplier_d = mplier;
      cnt_d    = cnt;
      opa_d    = opa;
      opb_d    = opb;
      aluop_d  = aluop;
      result_d = resp_result;
      zero_d   = resp_zero;
      acc_step = mplier[0] ? alu_result : acc;

      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_cmd == CMD_PASS) begin
                  opa_d   = req_a;
                  opb_d   = req_b;
                  aluop_d = req_aluop;
                  state_d = S_EXEC;
               end else if (req_b != '0) begin
                  acc_d    = '0;
                  mcand_d  = req_a;
                  mplier_d = req_b;
                  cnt_d    = '0;
                  state_d  = S_MUL_STEP;
               end else begin
                  result_d = '0;
                  zero_d   = 1'b1;
                  state_d  = S_DONE;
               end
            end
         end
         S_EXEC: begin
            result_d = alu_result;
            zero_d   = alu_z;
            state_d  = S_DONE;
         end
         S_MUL_STEP: begin
            acc_d    = acc_step;
            mcand_d  = mcand << 1;
            mplier_d = mplier >> 1;
            cnt_d    = cnt + CNTW'(1);
            if ((mplier_d == '0) || (cnt == CNTW'(WIDTH - 1))) begin
               result_d = acc_step;
               zero_d   = (acc_step == '0);
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      alu_a_d  = '0;
      alu_b_d  = '0;
      alu_op_d = OPW'(OP_IDLE);
      if (state_d == S_EXEC) begin
         alu_a_d  = opa_d;
         alu_b_d  = opb_d;
         alu_op_d = aluop_d;
      end else if (state_d == S_MUL_STEP) begin
         alu_a_d  = acc_d;
         alu_b_d  = mcand_d;
         alu_op_d = OPW'(OP_ADD);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         cnt         <= '0;
         opa         <= '0;
         opb         <= '0;
         aluop       <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_zero   <= 1'b0;
         busy        <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= OPW'(OP_IDLE);
      end else begin
         state       <= state_d;
         acc         <= acc_d;
         mcand       <= mcand_d;
         mplier      <= mplier_d;
         cnt         <= cnt_d;
         opa         <= opa_d;
         opb         <= opb_d;
         aluop       <= aluop_d;
         req_ready   <= (state_d == S_IDLE);
         resp_valid  <= (state_d == S_DONE);
         resp_result <= result_d;
         resp_zero   <= zero_d;
         busy        <= (state_d != S_IDLE);
         alu_a       <= alu_a_d;
         alu_b       <= alu_b_d;
         alu_op      <= alu_op_d;
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural alu and a result scoreboard.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned OPW   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid, req_ready, req_cmd;
   logic [OPW-1:0]   req_aluop;
   logic [WIDTH-1:0] req_a, req_b;
   logic             resp_valid, resp_ready, resp_zero, busy;
   logic [WIDTH-1:0] resp_result, alu_a, alu_b, alu_result;
   logic [OPW-1:0]   alu_op;
   logic             alu_z;

   typedef struct {
      logic             cmd;
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_res;
      logic             exp_zero;
      int               exp_lat;
      int               exp_steps;
      int               hold;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             zero;
   } sb_t;

   sb_t  sbq[$];
   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   alu_mul_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(7)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_aluop(req_aluop), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_zero(resp_zero), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_z(alu_z)
   );

   always #5 clk = ~clk;

   // Behavioural alu; unknown opcodes give 0.
   always_comb begin
      case (alu_op)
         OP_AND:   alu_result = alu_a & alu_b;
         OP_ORR:   alu_result = alu_a | alu_b;
         OP_ADD:   alu_result = alu_a + alu_b;
         OP_SUB:   alu_result = alu_a - alu_b;
         OP_NOR:   alu_result = ~(alu_a | alu_b);
         OP_PASSB: alu_result = alu_b;
         default:  alu_result = '0;
      endcase
      alu_z = (alu_result == '0);
   end

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic cmd, input logic [3:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r,
                               input logic z, input int lat, input int steps, input int hold);
      vec_t v;
      v.cmd = cmd; v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_zero = z;
      v.exp_lat = lat; v.exp_steps = steps; v.hold = hold;
      return v;
   endfunction

   function automatic vec_t mk_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int top;
      logic [WIDTH-1:0] p;
      top = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) top = i + 1;
      p = a * b;
      return mk(CMD_MUL, 4'h0, a, b, p, p == '0, top + 1, top, 0);
   endfunction

   // Wait for req_ready, offer the command for one accepting edge, push its expectation.
   task automatic issue(input vec_t v);
      int n;
      n = 0;
      while (!req_ready && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_cmd = v.cmd; req_aluop = v.op; req_a = v.a; req_b = v.b;
      sbq.push_back('{res: v.exp_res, zero: v.exp_zero});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Wait for the response, score it, optionally stall, then complete the handshake.
   task automatic collect(input vec_t v, input bit intrude);
      int lat, steps;
      logic [3:0] want_op;
      sb_t e;
      logic [WIDTH-1:0] r0;
      logic z0;
      lat = 1; steps = 0;
      want_op = (v.cmd == CMD_MUL) ? OP_ADD : v.op;
      while (!resp_valid && lat < 300) begin
         if (alu_op == want_op) steps++;
         if (intrude && lat <= 2) begin
            req_valid = 1'b1; req_cmd = CMD_MUL; req_a = 64'd100; req_b = 64'd100;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1; lat++;
      end
      req_valid = 1'b0;
      check("resp_timeout", {63'd0, resp_valid}, 64'd1);
      if (sbq.size() == 0) begin
         check("sb_underflow", 64'(sbq.size()), 64'd1);
         e = '{res: '0, zero: 1'b0};
      end else begin
         e = sbq.pop_front();
      end
      check("resp_result", resp_result, e.res);
      check("resp_zero", {63'd0, resp_zero}, {63'd0, e.zero});
      check("latency", 64'(lat), 64'(v.exp_lat));
      check("alu_op_cycles", 64'(steps), 64'(v.exp_steps));
      check("done_alu_idle", {60'd0, alu_op}, {60'd0, OP_IDLE});
      r0 = resp_result; z0 = resp_zero;
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         check("hold_result", resp_result, r0);
         check("hold_zero_valid", {62'd0, resp_zero, resp_valid}, {62'd0, z0, 1'b1});
         check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("post_hs_valid_ready", {62'd0, resp_valid, req_ready}, 64'd1);
   endtask

   initial begin
      vec_t v;
      int extra;
      reset = 1'b1; req_valid = 1'b0; req_cmd = 1'b0; req_aluop = '0;
      req_a = '0; req_b = '0; resp_ready = 1'b0;
      #1;
      check("rst_ready_busy", {62'd0, req_ready, busy}, 64'd2);
      check("rst_valid_zero", {62'd0, resp_valid, resp_zero}, 64'd0);
      check("rst_result", resp_result, 64'd0);
      check("rst_alu_op", {60'd0, alu_op}, {60'd0, OP_IDLE});
      check("rst_alu_ab", alu_a | alu_b, 64'd0);
      #12 reset = 1'b0;
      @(posedge clk); #1;

      vecs.push_back(mk(CMD_PASS, OP_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 2, 1, 0));
      vecs.push_back(mk(CMD_PASS, OP_SUB, 64'd9, 64'd9, 64'd0, 1'b1, 2, 1, 5));
      vecs.push_back(mk(CMD_PASS, OP_AND, 64'hF0, 64'h3C, 64'h30, 1'b0, 2, 1, 0));
      vecs.push_back(mk(CMD_PASS, OP_NOR, 64'd0, 64'd0, '1, 1'b0, 2, 1, 0));
      vecs.push_back(mk(CMD_PASS, 4'b1010, 64'd5, 64'd5, 64'd0, 1'b1, 2, 1, 0));
      vecs.push_back(mk(CMD_MUL, OP_SUB, 64'd7, 64'd6, 64'd42, 1'b0, 4, 3, 0));
      vecs.push_back(mk(CMD_MUL, 4'h0, 64'd3, 64'd0, 64'd0, 1'b1, 1, 0, 2));
      vecs.push_back(mk(CMD_MUL, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                        64'h8000_0000_0000_0000, 1'b0, 65, 64, 0));
      vecs.push_back(mk(CMD_MUL, 4'h0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1, 34, 33, 0));
      vecs.push_back(mk(CMD_MUL, 4'h0, 64'd12345, 64'd1, 64'd12345, 1'b0, 2, 1, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk_mul({$urandom, $urandom}, {32'd0, $urandom}));

      foreach (vecs[i]) begin
         issue(vecs[i]);
         collect(vecs[i], 1'b0);
      end

      // Reset at step 10 of a 64-step multiply.
      v = mk(CMD_MUL, 4'h0, '1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65, 64, 0);
      issue(v);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
      end
      check("mid_mul_busy", {60'd0, busy, alu_op[2:0]}, {60'd0, 1'b1, OP_ADD[2:0]});
      reset = 1'b1;
      #1;
      check("rst_mid_ready_valid", {62'd0, req_ready, resp_valid}, 64'd2);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_alu_op", {60'd0, alu_op}, {60'd0, OP_IDLE});
      sbq.delete();
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      v = mk(CMD_MUL, 4'h0, 64'd3, 64'd5, 64'd15, 1'b0, 4, 3, 0);
      issue(v);
      collect(v, 1'b0);

      // Requests while busy must be ignored.
      v = mk(CMD_MUL, 4'h0, 64'd7, 64'd6, 64'd42, 1'b0, 4, 3, 0);
      issue(v);
      collect(v, 1'b1);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (resp_valid || busy) extra++;
      end
      check("no_extra_response", 64'(extra), 64'd0);
      check("sb_empty", 64'(sbq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
